// File: rtl/rel_cmp_arbiter.sv
// rel_cmp_arbiter: round-robin shared relational comparator with IDLE/EXEC/RESP handshake FSM
module rel_cmp_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_op,
  input  logic             req0_sgn,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_op,
  input  logic             req1_sgn,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic             resp_result,
  output logic             resp_z,
  output logic             resp_n,
  output logic             resp_err,
  output logic             busy,
  output logic [15:0]      done_cnt
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, state_nx;
  logic last_grant, grant, port, sgn_q, acc, hs, eq, lt, rel, illegal;
  logic [2:0] op_q;
  logic [WIDTH-1:0] a_q, b_q;
  // grant is only meaningful while IDLE; a tie goes to the port not served last
  always_comb begin
    grant   = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
    acc     = req0_ready | req1_ready;
    hs      = (state == RESP) & (port ? resp1_ready : resp0_ready);
    eq      = a_q == b_q;
    lt      = sgn_q ? ($signed(a_q) < $signed(b_q)) : (a_q < b_q);
    illegal = op_q[2] & op_q[1];
    rel     = op_q == 3'd0 ? eq :
              op_q == 3'd1 ? ~eq :
              op_q == 3'd2 ? lt :
              op_q == 3'd3 ? (lt | eq) :
              op_q == 3'd4 ? ~(lt | eq) :
              op_q == 3'd5 ? ~lt : 1'b0;
  end
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else     state <= state_nx;
  always_comb
    state_nx = state == IDLE ? (acc ? EXEC : IDLE) :
               state == EXEC ? RESP :
               (hs ? IDLE : RESP);
  always_comb begin
    req0_ready  = (state == IDLE) & ~grant & req0_valid;
    req1_ready  = (state == IDLE) & grant & req1_valid;
    resp0_valid = (state == RESP) & ~port;
    resp1_valid = (state == RESP) & port;
    busy        = state != IDLE;
    resp_n      = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant  <= 1'b1;
      port        <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      sgn_q       <= 1'b0;
      resp_result <= 1'b0;
      resp_z      <= 1'b0;
      resp_err    <= 1'b0;
      done_cnt    <= '0;
    end else begin
      if (acc) begin
        a_q        <= grant ? req1_a : req0_a;
        b_q        <= grant ? req1_b : req0_b;
        op_q       <= grant ? req1_op : req0_op;
        sgn_q      <= grant ? req1_sgn : req0_sgn;
        port       <= grant;
        last_grant <= grant;
      end
      if (state == EXEC) begin
        resp_result <= rel;
        resp_z      <= ~rel;
        resp_err    <= illegal;
      end
      if (hs) done_cnt <= done_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_rel_cmp_arbiter.sv
// tb_rel_cmp_arbiter: vector table, directed corner sequences and random traffic against a reference model
module tb_rel_cmp_arbiter;
  logic clk = 0, rst = 1;
  logic req0_valid = 0, req1_valid = 0, req0_ready, req1_ready;
  logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic [2:0] req0_op = 0, req1_op = 0;
  logic req0_sgn = 0, req1_sgn = 0;
  logic resp0_valid, resp1_valid, resp0_ready = 1, resp1_ready = 1;
  logic resp_result, resp_z, resp_n, resp_err, busy;
  logic [15:0] done_cnt;
  int n_cmp = 0, n_fail = 0, cnt = 0;
  logic lg = 1;

  rel_cmp_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_op(req0_op), .req0_sgn(req0_sgn),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_op(req1_op), .req1_sgn(req1_sgn),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp_result(resp_result), .resp_z(resp_z), .resp_n(resp_n), .resp_err(resp_err),
    .busy(busy), .done_cnt(done_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int port;
    logic [31:0] a, b;
    logic [2:0] op;
    logic sgn, res, err;
  } vec_t;
  vec_t tv[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: widen both operands to 64-bit integers and compare arithmetically
  function automatic void ref_cmp(input logic [31:0] a, b, input logic [2:0] op, input logic sgn,
                                  output logic res, output logic err);
    longint x, y;
    x = sgn ? longint'($signed(a)) : longint'({32'd0, a});
    y = sgn ? longint'($signed(b)) : longint'({32'd0, b});
    err = op > 3'd5;
    case (op)
      3'd0: res = x == y;
      3'd1: res = x != y;
      3'd2: res = x < y;
      3'd3: res = x <= y;
      3'd4: res = x > y;
      3'd5: res = x >= y;
      default: res = 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 3))
      0: return $urandom;
      1: return 32'($urandom_range(0, 3));
      2: return 32'h8000_0000 + 32'($urandom_range(0, 2));
      default: return 32'hFFFF_FFFE + 32'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic drive(input int p, input logic [31:0] a, b, input logic [2:0] op, input logic s);
    if (p == 1) begin
      req1_a = a; req1_b = b; req1_op = op; req1_sgn = s; req1_valid = 1;
    end else begin
      req0_a = a; req0_b = b; req0_op = op; req0_sgn = s; req0_valid = 1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; req0_valid = 0; req1_valid = 0;
    @(negedge clk);
    rst = 0; lg = 1; cnt = 0;
  endtask

  // Called right after a negedge; returns at negedge+1 with the FSM back in IDLE
  task automatic serve(input int hold, input bit keep, output int p, output logic r, output logic e);
    int n, ep;
    logic [31:0] a, b;
    logic [2:0] op;
    logic s, er, ee;
    n = 0; p = 0; r = 0; e = 0;
    #1;
    while (!(req0_ready | req1_ready) && n < 40) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 40) begin
      n_cmp++; n_fail++;
      $display("FAIL grant_timeout: got no ready expected ready within 40 cycles");
      return;
    end
    p  = req1_ready ? 1 : 0;
    ep = (req0_valid && req1_valid) ? (lg ? 0 : 1) : (req1_valid ? 1 : 0);
    chk("single_ready", {31'd0, req0_ready & req1_ready}, 0);
    chk("grant_port", p, ep);
    lg = p[0];
    a = p ? req1_a : req0_a; b = p ? req1_b : req0_b;
    op = p ? req1_op : req0_op; s = p ? req1_sgn : req0_sgn;
    ref_cmp(a, b, op, s, er, ee);
    @(posedge clk);
    @(negedge clk);
    if (!keep) begin
      if (p == 1) req1_valid = 0; else req0_valid = 0;
    end
    if (p == 1) begin resp1_ready = hold == 0; resp0_ready = 1'($urandom); end
    else begin resp0_ready = hold == 0; resp1_ready = 1'($urandom); end
    #1;
    chk("exec_busy", {31'd0, busy}, 1);
    chk("exec_resp_valid", {31'd0, resp0_valid | resp1_valid}, 0);
    chk("exec_no_ready", {31'd0, req0_ready | req1_ready}, 0);
    for (int i = 0; i <= hold; i++) begin
      @(negedge clk); #1;
      chk("resp_valid", {31'd0, p == 1 ? resp1_valid : resp0_valid}, 1);
      chk("resp_other", {31'd0, p == 1 ? resp0_valid : resp1_valid}, 0);
      chk("resp_result", {31'd0, resp_result}, {31'd0, er});
      chk("resp_z", {31'd0, resp_z}, {31'd0, !er});
      chk("resp_n", {31'd0, resp_n}, 0);
      chk("resp_err", {31'd0, resp_err}, {31'd0, ee});
      chk("resp_no_ready", {31'd0, req0_ready | req1_ready}, 0);
      if (i == hold) begin
        if (p == 1) resp1_ready = 1; else resp0_ready = 1;
      end
    end
    r = resp_result; e = resp_err;
    @(negedge clk); #1;
    cnt++;
    chk("done_cnt", {16'd0, done_cnt}, cnt & 32'hFFFF);
    chk("idle_busy", {31'd0, busy}, 0);
    chk("idle_resp_valid", {31'd0, resp0_valid | resp1_valid}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 500us");
    $fatal(1);
  end

  initial begin
    int p;
    logic r, e;
    tv[0]  = '{0, 32'd1, 32'd1, 3'd3, 1'b0, 1'b1, 1'b0};
    tv[1]  = '{1, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 3'd4, 1'b1, 1'b1, 1'b0};
    tv[2]  = '{1, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 3'd2, 1'b0, 1'b0, 1'b0};
    tv[3]  = '{0, 32'd5, 32'd5, 3'd6, 1'b0, 1'b0, 1'b1};
    tv[4]  = '{0, 32'd5, 32'd5, 3'd0, 1'b0, 1'b1, 1'b0};
    tv[5]  = '{1, 32'd5, 32'd6, 3'd1, 1'b0, 1'b1, 1'b0};
    tv[6]  = '{0, 32'h8000_0000, 32'd1, 3'd2, 1'b1, 1'b1, 1'b0};
    tv[7]  = '{0, 32'h8000_0000, 32'd1, 3'd2, 1'b0, 1'b0, 1'b0};
    tv[8]  = '{1, 32'd7, 32'd7, 3'd5, 1'b1, 1'b1, 1'b0};
    tv[9]  = '{1, 32'd3, 32'd7, 3'd5, 1'b0, 1'b0, 1'b0};
    tv[10] = '{0, 32'd1, 32'd2, 3'd7, 1'b1, 1'b0, 1'b1};
    tv[11] = '{0, 32'hFFFF_FFFF, 32'd0, 3'd3, 1'b1, 1'b1, 1'b0};
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_resp_valid", {31'd0, resp0_valid | resp1_valid}, 0);
    chk("rst_flags", {28'd0, resp_result, resp_z, resp_n, resp_err}, 0);
    chk("rst_done_cnt", {16'd0, done_cnt}, 0);
    rst = 0; lg = 1; cnt = 0;
    @(negedge clk);
    // vector table
    foreach (tv[i]) begin
      drive(tv[i].port, tv[i].a, tv[i].b, tv[i].op, tv[i].sgn);
      serve(0, 0, p, r, e);
      chk("vec_port", p, tv[i].port);
      chk("vec_result", {31'd0, r}, {31'd0, tv[i].res});
      chk("vec_err", {31'd0, e}, {31'd0, tv[i].err});
    end
    // both ports valid continuously: strict alternation starting at port 0
    do_reset();
    drive(0, 32'd10, 32'd20, 3'd2, 1'b0);
    drive(1, 32'd20, 32'd10, 3'd4, 1'b1);
    for (int k = 0; k < 4; k++) begin
      serve(0, 1, p, r, e);
      chk("alt_grant", p, k % 2);
    end
    req0_valid = 0; req1_valid = 0;
    chk("alt_done_cnt", {16'd0, done_cnt}, 4);
    // resp0_ready held low for 10 cycles while port 1 waits
    do_reset();
    drive(0, 32'd9, 32'd4, 3'd4, 1'b0);
    drive(1, 32'd1, 32'd1, 3'd0, 1'b0);
    serve(10, 0, p, r, e);
    chk("hold_port", p, 0);
    serve(0, 0, p, r, e);
    chk("hold_next_port", p, 1);
    // reset during EXEC drops the transaction
    do_reset();
    drive(0, 32'd3, 32'd3, 3'd0, 1'b0);
    #1;
    chk("mid_rst_ready", {31'd0, req0_ready}, 1);
    @(posedge clk);
    @(negedge clk);
    rst = 1; req0_valid = 0;
    @(negedge clk); #1;
    chk("mid_rst_busy", {31'd0, busy}, 0);
    chk("mid_rst_resp_valid", {31'd0, resp0_valid | resp1_valid}, 0);
    chk("mid_rst_done_cnt", {16'd0, done_cnt}, 0);
    chk("mid_rst_flags", {28'd0, resp_result, resp_z, resp_n, resp_err}, 0);
    rst = 0; lg = 1; cnt = 0;
    @(negedge clk);
    drive(0, 32'd2, 32'd3, 3'd2, 1'b0);
    drive(1, 32'd3, 32'd2, 3'd2, 1'b0);
    serve(0, 0, p, r, e);
    chk("post_rst_tie", p, 0);
    serve(0, 0, p, r, e);
    // random traffic
    for (int it = 0; it < 150; it++) begin
      int m;
      m = $urandom_range(1, 3);
      if (m[0] && !req0_valid) drive(0, rnd_val(), rnd_val(), 3'($urandom_range(0, 7)), 1'($urandom));
      if (m[1] && !req1_valid) drive(1, rnd_val(), rnd_val(), 3'($urandom_range(0, 7)), 1'($urandom));
      serve($urandom_range(0, 3), 0, p, r, e);
    end
    while (req0_valid || req1_valid) serve(0, 0, p, r, e);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/rel_cmp_arbiter.md
# rel_cmp_arbiter

Shares one WIDTH-bit relational comparator between two requesters in the ALU/CU datapath. Each requester submits an operand pair plus a relational opcode through a valid/ready handshake. A round-robin arbiter grants one request at a time. A three-state FSM registers operands, evaluates the compare, and holds the result with z/n flags until the granted requester accepts it.

## Interface
- WIDTH, 32, operand width in bits
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req0_valid / req1_valid  input  1  request present on port 0 / 1
- req0_ready / req1_ready  output  1  request accepted this cycle when high with valid
- req0_a, req0_b / req1_a, req1_b  input  WIDTH  operands
- req0_op / req1_op  input  3  000 EQ, 001 NE, 010 LT, 011 LE, 100 GT, 101 GE, 110/111 illegal
- req0_sgn / req1_sgn  input  1  1 = two's-complement compare, 0 = unsigned
- resp0_valid / resp1_valid  output  1  result available for port 0 / 1
- resp0_ready / resp1_ready  input  1  requester accepts result
- resp_result  output  1  compare outcome (1 = relation true)
- resp_z  output  1  equals !resp_result
- resp_n  output  1  always 0 (relational family convention)
- resp_err  output  1  illegal opcode flag
- busy  output  1  FSM not in IDLE
- done_cnt  output  16  completed transactions, wraps at 0xFFFF -> 0

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: grant is computed combinationally from the valids and the last_grant register.
  - Only one valid: grant that port.
  - Both valid: grant the port != last_grant.
  - reqN_ready = (state==IDLE) & grant==N & reqN_valid.
- Accept (valid & ready):
  - Latch a, b, op, sgn, and port id.
  - last_grant <= port.
  - Go to EXEC.
- EXEC:
  - Evaluate the relation on the latched operands. Signed compare when sgn=1, unsigned otherwise.
  - Register resp_result, resp_z = !result, resp_n = 0.
  - Illegal op: result=0, z=1, err=1. Legal op: err=0.
  - Go to RESP.
- RESP:
  - Assert respN_valid for the latched port only. The other port's resp_valid stays 0.
  - Hold result and flags stable until respN_ready.
  - On handshake: done_cnt += 1, then IDLE.
- Both req_ready outputs are 0 outside IDLE. Requests arriving then must be held by the requester (valid stays high, payload stable).
- Reset values:
  - state IDLE, last_grant 1 (port 0 wins the first tie).
  - All resp_valid, req_ready (registered component), resp_result, resp_z, resp_n, resp_err, busy = 0.
  - done_cnt = 0.
- rst mid-operation (EXEC or RESP):
  - Transaction dropped, no response issued, done_cnt not incremented.
  - Outputs return to reset values on the next edge.

## Timing
- Accept at edge T -> EXEC during cycle T+1 -> respN_valid high from edge T+2.
- Minimum occupancy 3 cycles per transaction (IDLE, EXEC, RESP with resp_ready already high). Back-to-back throughput: 1 result per 3 cycles.
- With resp_ready held low, RESP persists indefinitely. No timeout.
- resp_ready asserted in the same cycle resp_valid first rises completes the handshake at that edge.
- resp_ready for the non-granted port is ignored.
- busy = (state != IDLE), registered, so it is high from T+1 through the RESP handshake cycle.
- Simultaneous requests: exactly one ready high. The loser is granted in the next IDLE if it is still valid.

## Test plan
- Reset then port 0 LE unsigned, a=1 b=1 -> resp0_valid at T+2, result=1 z=0 n=0 err=0, done_cnt=1.
- Port 1 GT signed, a=-1 (0xFFFFFFFF) b=-2 -> result=1. Same operands with sgn=0 and op LT -> result=0, z=1.
- Both ports valid continuously for 4 transactions -> grants alternate 0,1,0,1 and done_cnt=4. No ready is issued while busy=1.
- Port 0 op=110 -> result=0, z=1, err=1. A following legal EQ a=5 b=5 clears err to 0 with result=1.
- resp0_ready held low 10 cycles -> resp0_valid and payload held stable, req1_ready=0 throughout. Releasing resp0_ready returns the FSM to IDLE the next cycle.
- rst asserted during EXEC -> no resp_valid, busy=0 and done_cnt unchanged after the edge. A subsequent tie goes to port 0.
